// File: rtl/led_scan_ctrl_pkg.sv
// Shared types and constants for the LED scan controller: digit byte type,
// digit geometry and the hex-to-segment lookup table.
package led_pkg;

  typedef logic [7:0] digit_t;

  localparam int DIGITS_PER_BANK  = 8;
  localparam int DIGITS_PER_GROUP = 4;

  // Segment patterns, bit order gfedcba, active-high
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Display-write channels, brightness and board-side outputs of the scan controller.
interface led_scan_ctrl_if #(
  parameter int NCH   = 8,
  parameter int NBANK = 8
);
  localparam int PW = $clog2(2 * NBANK);

  logic [NCH-1:0]         wr_en;
  logic [NCH-1:0][15:0]   wr_dat;
  logic [NCH-1:0][PW-1:0] wr_pos;
  logic [NCH-1:0]         wr_raw;
  logic [NCH-1:0][3:0]    wr_dp;
  logic [2:0]             bright;
  logic [7:0][7:0]        seg_o;
  logic [NBANK-1:0]       ctrl_o;

  modport master (
    output wr_en, wr_dat, wr_pos, wr_raw, wr_dp, bright,
    input  seg_o, ctrl_o
  );

  modport slave (
    input  wr_en, wr_dat, wr_pos, wr_raw, wr_dp, bright,
    output seg_o, ctrl_o
  );

endinterface

// File: rtl/led_scan_ctrl_hex7seg.sv
// Combinational nibble to 7-segment (gfedcba) decoder.
module hex7seg
  import led_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/led_scan_ctrl.sv
// Multiplexed multi-bank 7-segment controller: merges NCH write channels into
// digit storage and scans one bank at a time with blanking and brightness PWM.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int NBANK     = 8,
  parameter int SLOT_LOG2 = 10,
  parameter int BLANK     = 2
) (
  input  logic            clk,
  input  logic            reset,
  led_scan_ctrl_if.slave  bus
);

  localparam int NDIG = DIGITS_PER_BANK * NBANK;
  localparam int BW   = $clog2(NBANK);

  logic [6:0] hex_seg [NCH][DIGITS_PER_GROUP];
  digit_t     mem     [NDIG];
  digit_t     mem_nxt [NDIG];

  logic [SLOT_LOG2-1:0] sub;
  logic [BW-1:0]        bank;
  logic                 lit;
  logic [NBANK-1:0]     ctrl_nxt;
  logic [NBANK-1:0]     ctrl_p1;
  digit_t               seg_p1 [DIGITS_PER_BANK];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar k = 0; k < DIGITS_PER_GROUP; k++) begin : g_dig
      hex7seg u_hex (
        .nib (bus.wr_dat[c][4*k +: 4]),
        .seg (hex_seg[c][k])
      );
    end
  end

  // Ascending channel order lets the highest index overwrite shared digits
  always_comb begin
    mem_nxt = mem;
    for (int c = 0; c < NCH; c++) begin
      if (bus.wr_en[c]) begin
        if (bus.wr_raw[c]) begin
          mem_nxt[{bus.wr_pos[c], 2'd0}] = bus.wr_dat[c][7:0];
          mem_nxt[{bus.wr_pos[c], 2'd1}] = bus.wr_dat[c][15:8];
        end else begin
          for (int k = 0; k < DIGITS_PER_GROUP; k++) begin
            mem_nxt[{bus.wr_pos[c], 2'(k)}] = {bus.wr_dp[c][k], hex_seg[c][k]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) mem[i] <= '0;
    end else begin
      mem <= mem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub  <= '0;
      bank <= '0;
    end else begin
      sub <= sub + 1'b1;
      if (&sub) bank <= bank + 1'b1;
    end
  end

  always_comb begin
    lit      = (bus.bright != 3'd0) &&
               (sub[SLOT_LOG2-1 -: 3] < bus.bright) &&
               (sub >= SLOT_LOG2'(BLANK));
    ctrl_nxt = lit ? (NBANK'(1) << bank) : '0;
  end

  // Output stage: segments latch only at slot start, while ctrl is blanked
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1 <= '0;
      for (int j = 0; j < DIGITS_PER_BANK; j++) seg_p1[j] <= '0;
    end else begin
      ctrl_p1 <= ctrl_nxt;
      if (sub == '0) begin
        for (int j = 0; j < DIGITS_PER_BANK; j++) seg_p1[j] <= mem[{bank, 3'(j)}];
      end
    end
  end

  assign bus.ctrl_o = ctrl_p1;
  for (genvar j = 0; j < DIGITS_PER_BANK; j++) begin : g_seg
    assign bus.seg_o[j] = seg_p1[j];
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized scoreboard bench for led_scan_ctrl against a slot-level reference model.
module tb_led_scan_ctrl;

  localparam int NCH = 2, NBANK = 2, SLOT_LOG2 = 4, BLANK = 2;
  localparam int SLOT = 1 << SLOT_LOG2;
  localparam int NDIG = 8 * NBANK;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_scan_ctrl_if #(.NCH(NCH), .NBANK(NBANK)) bus ();

  led_scan_ctrl #(.NCH(NCH), .NBANK(NBANK), .SLOT_LOG2(SLOT_LOG2), .BLANK(BLANK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0][7:0]  seg;
    logic [NBANK-1:0] ctrl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: digit bytes, currently shown bytes, cycles since reset
  logic [7:0]      mem_m [NDIG];
  logic [7:0][7:0] seg_m;
  int              t_m;

  byte unsigned hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic step();
    exp_t e;
    int   sub, bnk, eighth, base;
    if (reset) begin
      for (int i = 0; i < NDIG; i++) mem_m[i] = 8'h00;
      e.seg  = '0;
      e.ctrl = '0;
      t_m    = 0;
    end else begin
      sub    = t_m % SLOT;
      bnk    = (t_m / SLOT) % NBANK;
      eighth = sub / (SLOT / 8);
      e.ctrl = (bus.bright != 0 && eighth < int'(bus.bright) && sub >= BLANK)
               ? NBANK'(1 << bnk) : '0;
      if (sub == 0) for (int j = 0; j < 8; j++) e.seg[j] = mem_m[bnk*8 + j];
      else e.seg = seg_m;
      for (int c = 0; c < NCH; c++) begin
        if (bus.wr_en[c]) begin
          base = int'(bus.wr_pos[c]) * 4;
          if (bus.wr_raw[c]) begin
            mem_m[base]     = bus.wr_dat[c][7:0];
            mem_m[base + 1] = bus.wr_dat[c][15:8];
          end else begin
            for (int k = 0; k < 4; k++)
              mem_m[base + k] = {bus.wr_dp[c][k], hex_tbl[(bus.wr_dat[c] >> (4*k)) & 16'hF][6:0]};
          end
        end
      end
      t_m++;
    end
    seg_m = e.seg;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.seg_o !== e.seg || bus.ctrl_o !== e.ctrl) begin
        errors++;
        $display("FAIL scan t=%0t seg=%h ctrl=%b expected seg=%h ctrl=%b",
                 $time, bus.seg_o, bus.ctrl_o, e.seg, e.ctrl);
      end
    end
  end

  task automatic idle_wr();
    bus.wr_en = '0; bus.wr_dat = '0; bus.wr_pos = '0; bus.wr_raw = '0; bus.wr_dp = '0;
  endtask

  task automatic wait_ctrl(input logic [NBANK-1:0] want);
    int n = 0;
    while (bus.ctrl_o !== want && n < 3 * SLOT) begin
      step();
      n++;
    end
    checks++;
    if (bus.ctrl_o !== want) begin
      errors++;
      $display("FAIL wait_ctrl got %b wanted %b", bus.ctrl_o, want);
    end
  endtask

  task automatic chk_seg(input string name, input logic [63:0] want);
    checks++;
    if (bus.seg_o !== want) begin
      errors++;
      $display("FAIL %s seg=%h expected %h", name, bus.seg_o, want);
    end
  endtask

  initial begin
    idle_wr();
    bus.bright = 3'd7;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Hex write 0x1234 to group 0 with dp on digit 0, then a colliding pair on group 1
    bus.wr_en[0] = 1'b1; bus.wr_dat[0] = 16'h1234; bus.wr_pos[0] = 2'd0; bus.wr_dp[0] = 4'b0001;
    step();
    idle_wr();
    bus.wr_en = 2'b11;
    bus.wr_dat[0] = 16'hFFFF; bus.wr_pos[0] = 2'd1; bus.wr_raw[0] = 1'b0;
    bus.wr_dat[1] = 16'hAA55; bus.wr_pos[1] = 2'd1; bus.wr_raw[1] = 1'b1;
    step();
    idle_wr();
    repeat (2 * NBANK * SLOT) step();

    wait_ctrl(2'b01);
    chk_seg("bank0_bytes", 64'h7171_AA55_065B_4FE6);
    wait_ctrl(2'b10);
    chk_seg("bank1_bytes", 64'h0);

    bus.bright = 3'd0;
    bus.wr_en[1] = 1'b1; bus.wr_dat[1] = 16'h9A3C; bus.wr_pos[1] = 2'd2;
    step();
    idle_wr();
    repeat (NBANK * SLOT) step();
    bus.bright = 3'd2;
    repeat (NBANK * SLOT) step();
    bus.bright = 3'd7;

    // Write during sub=0 of bank 0, then reset partway through the slot
    while (t_m % (NBANK * SLOT) != 0) step();
    bus.wr_en[0] = 1'b1; bus.wr_dat[0] = 16'h8888; bus.wr_pos[0] = 2'd0;
    step();
    idle_wr();
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (NBANK * SLOT + 8) step();

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) bus.bright = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NCH; c++) begin
        bus.wr_en[c]  = ($urandom_range(0, 3) == 0);
        bus.wr_dat[c] = 16'($urandom);
        bus.wr_pos[c] = 2'($urandom_range(0, 3));
        bus.wr_raw[c] = 1'($urandom_range(0, 1));
        bus.wr_dp[c]  = 4'($urandom);
      end
      step();
    end
    reset = 1'b0;
    idle_wr();
    step();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
# led_scan_ctrl

Multiplexed 7-segment display controller for a multi-bank LED board, with several independent write channels. Each bank holds 8 digits. It drives one bank at a time through a shared 8-digit segment bus, stepping round the banks in turn. It stores digit patterns written by up to NCH producers, in hex-decoded or raw-segment form. It scans the banks with a configurable slot length, anti-ghosting blanking and 3-bit brightness PWM. It sits between the core's display-write ports and the board's segment/digit-select pins.

## Interface
- NCH, 8, number of write channels
- NBANK, 8, number of banks (8 digits each); power of two, ≥2
- SLOT_LOG2, 10, log2 of cycles per bank slot; ≥4
- BLANK, 2, blanked cycles at the start of each slot; 1 ≤ BLANK < 2^(SLOT_LOG2-3)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  [NCH]  per-channel write strobe
- wr_dat  in  [NCH][16]  write data
- wr_pos  in  [NCH][PW]  4-digit group index, PW = $clog2(2*NBANK)
- wr_raw  in  [NCH]  1: raw segment write; 0: hex decode
- wr_dp  in  [NCH][4]  decimal points for hex writes (bit i goes to digit i of the group)
- bright  in  3  brightness; 0 = display off
- seg_o  out  [8][8]  segment bytes for the 8 digits of the active bank; bit 0..6 = a..g, bit 7 = dp; active-high
- ctrl_o  out  NBANK  one-hot bank select; all-zero while blanked

## Operation
- Storage: 8*NBANK digit bytes. Digit d = pos*4+k.
- Hex write (wr_raw=0) to group p:
  - digit p*4+k ← {wr_dp[k], hex(wr_dat[4k+3:4k])}, for k=0..3.
- Raw write (wr_raw=1) to group p:
  - digit p*4+0 ← wr_dat[7:0]
  - digit p*4+1 ← wr_dat[15:8]
  - digits p*4+2 and p*4+3 unchanged.
- All enabled channels commit on the same edge. If two channels touch the same digit, the highest channel index wins. Non-overlapping digits from different channels all commit.
- Hex table (gfedcba):
  - 0–7: 3F 06 5B 4F 66 6D 7D 07
  - 8–F: 7F 6F 77 7C 39 5E 79 71
- Scan counters: sub (SLOT_LOG2 bits) and bank.
  - sub increments every cycle.
  - When sub is all-ones, sub wraps to 0 and bank advances by 1 mod NBANK.
- Registered outputs:
  - ctrl_o(t+1) = onehot(bank_t) if all of the following hold at t, else 0:
    - bright_t ≠ 0
    - sub_t[SLOT_LOG2-1 -: 3] < bright_t
    - sub_t ≥ BLANK
  - seg_o(t+1) ← storage of bank_t (digits bank_t*8 .. bank_t*8+7) when sub_t = 0; otherwise seg_o holds.
- Reset:
  - all storage bytes = 0x00
  - seg_o = all 0x00
  - ctrl_o = 0
  - sub = 0, bank = 0
  - Reset mid-slot takes effect on the next edge; writes in the reset cycle are discarded.

## Timing
- Write latency: storage is updated 1 edge after wr_en. The new value appears on seg_o at the next slot start of that bank.
  - A write during the sub=0 cycle of its own bank is not visible in that slot; seg_o samples pre-edge storage.
- seg_o changes only on the edge after sub=0. ctrl_o is zero on that edge because BLANK ≥ 1, so segments are always stable while any select is high.
- Active-cycle range per slot:
  - First possible active ctrl_o cycle: sub = BLANK, seen one cycle later.
  - Last possible active cycle: top3 = bright-1.
  - Duty is roughly bright/8 minus the blanking; bright = 7 leaves the final 1/8 of the slot dark.
- bright is sampled every cycle. A change takes effect on the next cycle, even mid-slot.
- Frame period: NBANK * 2^SLOT_LOG2 cycles.

## Structure
- Package led_pkg:
  - digit byte typedef (logic [7:0])
  - DIGITS_PER_BANK = 8, DIGITS_PER_GROUP = 4
  - 16-entry hex segment constant table
- Sub-module hex7seg: combinational 4-bit → 7-bit lookup from led_pkg, instantiated 4×NCH.
- Top level: write-merge loop over channels in ascending index order (so the highest index wins), storage array, scan counters, output registers.

## Test plan
Bench uses NBANK=2, SLOT_LOG2=4, BLANK=2, NCH=2.
- **Reset:** reset high 3 cycles → seg_o all 0x00, ctrl_o = 0; first ctrl_o = 01 at 3 cycles after release (sub=2 registered).
- **Hex write:** ch0 hex write 0x1234, pos 0, dp = 4'b0001, bright = 7 → bank-0 slot shows seg_o[0..3] = E6, 4F, 5B, 06. ctrl_o = 01 on cycles sub 2..13, seen one cycle later; 0 elsewhere.
- **Collision:** same cycle, ch0 hex 0xFFFF pos 1 and ch1 raw 0xAA55 pos 1 → digits 4, 5 = 55, AA; digits 6, 7 = 71, 71.
- **Brightness:** bright = 0 → ctrl_o stays 0 for a full frame while seg_o still updates. bright = 2 → ctrl_o high only for sub 2..3.
- **Bank wrap:** run 2 frames → ctrl_o sequence 01, 10, 01, 10 each 16 cycles apart. seg_o = bank-1 bytes during 10, bank-0 bytes during 01.
- **Mid-operation reset:** write during sub=0 of bank 0, then reset mid-slot → write not shown, storage cleared, counters restart at sub=0, bank=0.
